// File: rtl/clock_hms_core.sv
// Hours/minutes/seconds time-of-day core with two-button setting and a 4-digit muxed 7-segment scan.
// Optional field blinking in the set modes is enabled by defining CLOCK_HMS_BLINK_EN.

module clock_hms_key #(
    parameter int DEBOUNCE = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic          sync1, sync2;
    logic          level, level_q;
    logic [1:0]    settle;
    logic          armed;
    logic [DW-1:0] cnt;

    // NOTE: every register here is updated with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            settle  <= 2'b00;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            settle  <= {settle[0], 1'b1};
            // A key held through reset stays disarmed until it is seen released.
            if (settle[1] && !sync2)
                armed <= 1'b1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = armed & level & ~level_q;
endmodule

module clock_hms_core #(
    parameter int TICK_DIV = 65536,
    parameter int DEBOUNCE = 1024,
    parameter int SCAN_DIV = 256,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_add,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_sel,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       sec_pulse
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    mode_t         state;
    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          mode_press, add_press, tick;

    clock_hms_key #(.DEBOUNCE(DEBOUNCE)) u_key_mode (
        .clk(clk), .reset(reset), .raw(key_mode), .press(mode_press)
    );
    clock_hms_key #(.DEBOUNCE(DEBOUNCE)) u_key_add (
        .clk(clk), .reset(reset), .raw(key_add), .press(add_press)
    );

    assign tick = (presc == PW'(TICK_DIV - 1)) && (state == RUN);
    assign mode = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Ticks only happen in RUN and adds only in the set modes, so they never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            hour      <= '0;
            minute    <= '0;
            second    <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
            if (tick) begin
                if (second == 6'd59) begin
                    second <= '0;
                    if (minute == 6'd59) begin
                        minute <= '0;
                        hour   <= (hour == 5'(HOUR_MOD - 1)) ? 5'd0 : hour + 5'd1;
                    end else begin
                        minute <= minute + 6'd1;
                    end
                end else begin
                    second <= second + 6'd1;
                end
            end else if (add_press && !mode_press) begin
                case (state)
                    SET_H:   hour   <= (hour == 5'(HOUR_MOD - 1)) ? 5'd0 : hour + 5'd1;
                    SET_M:   minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                    SET_S:   second <= (second == 6'd59) ? 6'd0 : second + 6'd1;
                    default: ;
                endcase
            end
            if (mode_press) begin
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    endfunction

    logic [5:0] left_val, right_val;
    logic [3:0] digit_val;
    logic       blank;

    // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        left_val  = {1'b0, hour};
        right_val = minute;
        if (state == SET_S) begin
            left_val  = minute;
            right_val = second;
        end
        digit_val = 4'd0;
        case (idx)
            2'd3:    digit_val = 4'(left_val / 6'd10);
            2'd2:    digit_val = 4'(left_val % 6'd10);
            2'd1:    digit_val = 4'(right_val / 6'd10);
            default: digit_val = 4'(right_val % 6'd10);
        endcase
    end

`ifdef CLOCK_HMS_BLINK_EN
    // The field being set sits on digits 3/2 in SET_H and on digits 1/0 in SET_M and SET_S.
    assign blank = (presc >= PW'(TICK_DIV / 2)) &&
                   (((state == SET_H) && idx[1]) ||
                    (((state == SET_M) || (state == SET_S)) && !idx[1]));
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg       <= 7'h7F;
            dp        <= 1'b1;
            digit_sel <= 4'hF;
        end else begin
            seg       <= blank ? 7'h7F : glyph(digit_val);
            dp        <= !((idx == 2'd2) && !second[0]);
            digit_sel <= ~(4'b0001 << idx);
        end
    end
endmodule
